subterranean_aead_sequencer: RTL and testbench



---
 rtl/subterranean_aead_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_subterranean_aead_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subterranean_aead_sequencer.sv
// Host-side sequencer for a single-duplex Subterranean rounds core.
// Issues the Subterranean-2.0 AEAD duplex-call sequence and routes host/core/output handshakes.
module subterranean_aead_sequencer (
    input  logic        clk,
    input  logic        arstn,
    input  logic        start,
    input  logic        mode_decrypt,
    output logic        busy,
    output logic        done,
    output logic        tag_ok,
    input  logic [31:0] s_data,
    input  logic [2:0]  s_size,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic [2:0]  m_size,
    output logic        m_last,
    output logic        m_tag,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        core_enable,
    output logic        core_init,
    output logic        core_encrypt,
    output logic        core_decrypt,
    output logic [31:0] core_din,
    output logic [2:0]  core_din_size,
    output logic        core_din_valid,
    input  logic        core_din_ready,
    input  logic [31:0] core_dout,
    input  logic        core_dout_valid,
    output logic        core_dout_ready
);

    // state       | meaning
    // IDLE        | waiting for start
    // INIT        | clear core state
    // KEY/NONCE   | absorb 4 host words as full words
    // *_PAD       | one empty call closing a segment
    // BLANK1/2    | 8 empty calls
    // AD / MSG    | host segment words until s_last
    // TAG         | 4 squeeze calls (output or compare)
    // DONE        | one-cycle done pulse
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_KEY, S_KEY_PAD, S_NONCE, S_NONCE_PAD, S_BLANK1,
        S_AD, S_AD_PAD, S_MSG, S_MSG_PAD, S_BLANK2, S_TAG, S_DONE
    } state_t;

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       mode;
    logic [2:0] size_sat;
    logic       fire;

    assign size_sat = (s_size > 3'd4) ? 3'd4 : s_size;
    assign fire     = core_din_valid & core_din_ready;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state  <= S_IDLE;
            cnt    <= 3'd0;
            mode   <= 1'b0;
            tag_ok <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IDLE && start) begin
                mode   <= mode_decrypt;
                tag_ok <= 1'b1;
            end else if (state == S_TAG && mode && fire) begin
                tag_ok <= tag_ok & (core_dout == s_data);
            end
        end
    end

    // cnt is a down-counter loaded on segment entry; terminal count is zero
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE:      if (start) state_next = S_INIT;
            S_INIT: begin
                state_next = S_KEY;
                cnt_next   = 3'd3;
            end
            S_KEY: if (fire) begin
                if (cnt == 3'd0) state_next = S_KEY_PAD;
                else             cnt_next   = cnt - 3'd1;
            end
            S_KEY_PAD: if (fire) begin
                state_next = S_NONCE;
                cnt_next   = 3'd3;
            end
            S_NONCE: if (fire) begin
                if (cnt == 3'd0) state_next = S_NONCE_PAD;
                else             cnt_next   = cnt - 3'd1;
            end
            S_NONCE_PAD: if (fire) begin
                state_next = S_BLANK1;
                cnt_next   = 3'd7;
            end
            S_BLANK1: if (fire) begin
                if (cnt == 3'd0) state_next = S_AD;
                else             cnt_next   = cnt - 3'd1;
            end
            S_AD: if (fire && s_last) begin
                state_next = (size_sat == 3'd4) ? S_AD_PAD : S_MSG;
            end
            S_AD_PAD:    if (fire) state_next = S_MSG;
            S_MSG: if (fire && s_last) begin
                if (size_sat == 3'd4) begin
                    state_next = S_MSG_PAD;
                end else begin
                    state_next = S_BLANK2;
                    cnt_next   = 3'd7;
                end
            end
            S_MSG_PAD: if (fire) begin
                state_next = S_BLANK2;
                cnt_next   = 3'd7;
            end
            S_BLANK2: if (fire) begin
                if (cnt == 3'd0) begin
                    state_next = S_TAG;
                    cnt_next   = 3'd3;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            S_TAG: if (fire) begin
                if (cnt == 3'd0) state_next = S_DONE;
                else             cnt_next   = cnt - 3'd1;
            end
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);
        core_enable     = 1'b0;
        core_init       = 1'b0;
        core_encrypt    = 1'b0;
        core_decrypt    = 1'b0;
        core_din        = 32'd0;
        core_din_size   = 3'd0;
        core_din_valid  = 1'b0;
        core_dout_ready = 1'b0;
        s_ready         = 1'b0;
        m_valid         = 1'b0;
        m_data          = 32'd0;
        m_size          = 3'd0;
        m_last          = 1'b0;
        m_tag           = 1'b0;
        case (state)
            S_INIT: core_init = 1'b1;
            S_KEY, S_NONCE, S_AD: begin
                core_enable     = 1'b1;
                core_din        = s_data;
                core_din_size   = (state == S_AD) ? size_sat : 3'd4;
                core_din_valid  = s_valid;
                s_ready         = core_din_ready;
                core_dout_ready = 1'b1;
            end
            S_MSG: begin
                core_enable     = 1'b1;
                core_encrypt    = ~mode;
                core_decrypt    = mode;
                core_din        = s_data;
                core_din_size   = size_sat;
                core_din_valid  = s_valid;
                s_ready         = core_din_ready;
                core_dout_ready = m_ready;
                m_valid         = core_dout_valid;
                m_data          = core_dout;
                m_size          = size_sat;
                m_last          = s_last;
            end
            S_KEY_PAD, S_NONCE_PAD, S_BLANK1, S_AD_PAD, S_MSG_PAD, S_BLANK2: begin
                core_enable     = 1'b1;
                core_din_valid  = 1'b1;
                core_dout_ready = 1'b1;
            end
            S_TAG: begin
                core_enable = 1'b1;
                if (mode) begin
                    core_din_valid  = s_valid;
                    s_ready         = core_din_ready;
                    core_dout_ready = 1'b1;
                end else begin
                    core_din_valid  = 1'b1;
                    core_dout_ready = m_ready;
                    m_valid         = core_dout_valid;
                    m_data          = core_dout;
                    m_size          = 3'd4;
                    m_tag           = 1'b1;
                    m_last          = (cnt == 3'd0);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_subterranean_aead_sequencer.sv
// Bench for subterranean_aead_sequencer: toy duplex core, host/output stream drivers,
// and a call-list reference model derived from the AEAD sequence rules.
module tb_subterranean_aead_sequencer;

    typedef struct packed { logic [31:0] data; logic [2:0] size; logic last; } hw_t;
    typedef struct packed { logic [31:0] din; logic [2:0] size; logic enc; logic dec; } call_t;
    typedef struct packed { logic [31:0] data; logic [2:0] size; logic last; logic tag; } out_t;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0, mode_decrypt = 1'b0;
    logic        busy, done, tag_ok;
    logic [31:0] s_data = 32'd0;
    logic [2:0]  s_size = 3'd0;
    logic        s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic [31:0] m_data;
    logic [2:0]  m_size;
    logic        m_last, m_tag, m_valid;
    logic        m_ready = 1'b0;
    logic        core_enable, core_init, core_encrypt, core_decrypt;
    logic [31:0] core_din, core_dout;
    logic [2:0]  core_din_size;
    logic        core_din_valid, core_din_ready, core_dout_valid, core_dout_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    subterranean_aead_sequencer dut (
        .clk(clk), .arstn(arstn), .start(start), .mode_decrypt(mode_decrypt),
        .busy(busy), .done(done), .tag_ok(tag_ok),
        .s_data(s_data), .s_size(s_size), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_size(m_size), .m_last(m_last), .m_tag(m_tag),
        .m_valid(m_valid), .m_ready(m_ready),
        .core_enable(core_enable), .core_init(core_init),
        .core_encrypt(core_encrypt), .core_decrypt(core_decrypt),
        .core_din(core_din), .core_din_size(core_din_size), .core_din_valid(core_din_valid),
        .core_din_ready(core_din_ready), .core_dout(core_dout), .core_dout_valid(core_dout_valid),
        .core_dout_ready(core_dout_ready)
    );

    // Toy duplex permutation standing in for the Subterranean software model
    function automatic logic [31:0] mask_of(input logic [2:0] sz);
        case (sz)
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'h0000_00ff;
            3'd2:    return 32'h0000_ffff;
            3'd3:    return 32'h00ff_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    function automatic logic [31:0] z_of(input logic [63:0] s);
        return s[63:32] ^ s[31:0];
    endfunction

    function automatic logic [63:0] mix(input logic [63:0] s, input logic [31:0] x, input logic [2:0] sz);
        logic [63:0] t;
        t = (s ^ {x, ~x}) * 64'h9E37_79B9_7F4A_7C15;
        return (t ^ (t >> 29)) + {61'd0, sz} + 64'd1;
    endfunction

    function automatic logic [2:0] sat(input logic [2:0] sz);
        return (sz > 3'd4) ? 3'd4 : sz;
    endfunction

    logic [63:0] cs;
    call_t       call_log[$];
    int          init_cnt = 0;

    assign core_din_ready  = core_enable & core_dout_ready;
    assign core_dout_valid = core_din_valid & core_enable;
    assign core_dout = (core_encrypt | core_decrypt)
                       ? ((core_din ^ z_of(cs)) & mask_of(core_din_size)) : z_of(cs);

    always @(posedge clk) begin
        if (core_init) begin
            cs <= 64'd0;
            init_cnt <= init_cnt + 1;
        end else if (core_din_valid && core_din_ready) begin
            cs <= mix(cs, core_decrypt ? core_dout : (core_din & mask_of(core_din_size)), core_din_size);
            call_log.push_back({core_din, core_din_size, core_encrypt, core_decrypt});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    hw_t   op_key[4], op_nonce[4], op_tag[4];
    hw_t   op_ad[$], op_msg[$];
    call_t exp_calls[$];
    out_t  exp_out[$], got_out[$];
    logic  exp_tag_ok;
    int    exp_lat;

    // Reference: enumerate the duplex calls the AEAD sequence requires, then run the toy duplex over them
    task automatic build_expect(input bit dec);
        byte   kind[$];
        logic  mlast[$];
        logic [63:0] s;
        logic [31:0] z, d;
        int    t, a_calls, m_calls;
        exp_calls.delete(); exp_out.delete();
        for (int i = 0; i < 4; i++) begin exp_calls.push_back({op_key[i].data, 3'd4, 2'b00}); kind.push_back(0); mlast.push_back(0); end
        exp_calls.push_back('0); kind.push_back(0); mlast.push_back(0);
        for (int i = 0; i < 4; i++) begin exp_calls.push_back({op_nonce[i].data, 3'd4, 2'b00}); kind.push_back(0); mlast.push_back(0); end
        exp_calls.push_back('0); kind.push_back(0); mlast.push_back(0);
        for (int i = 0; i < 8; i++) begin exp_calls.push_back('0); kind.push_back(0); mlast.push_back(0); end
        a_calls = op_ad.size();
        foreach (op_ad[i]) begin exp_calls.push_back({op_ad[i].data, sat(op_ad[i].size), 2'b00}); kind.push_back(0); mlast.push_back(0); end
        if (sat(op_ad[op_ad.size()-1].size) == 3'd4) begin
            exp_calls.push_back('0); kind.push_back(0); mlast.push_back(0); a_calls++;
        end
        m_calls = op_msg.size();
        foreach (op_msg[i]) begin
            exp_calls.push_back({op_msg[i].data, sat(op_msg[i].size), ~dec, dec});
            kind.push_back(1); mlast.push_back(op_msg[i].last);
        end
        if (sat(op_msg[op_msg.size()-1].size) == 3'd4) begin
            exp_calls.push_back('0); kind.push_back(0); mlast.push_back(0); m_calls++;
        end
        for (int i = 0; i < 8; i++) begin exp_calls.push_back('0); kind.push_back(0); mlast.push_back(0); end
        for (int i = 0; i < 4; i++) begin exp_calls.push_back('0); kind.push_back(2); mlast.push_back(0); end
        exp_lat = 31 + a_calls + m_calls;
        s = 64'd0; t = 0; exp_tag_ok = 1'b1;
        foreach (exp_calls[i]) begin
            z = z_of(s);
            d = (exp_calls[i].enc | exp_calls[i].dec) ? ((exp_calls[i].din ^ z) & mask_of(exp_calls[i].size)) : z;
            if (kind[i] == 1) exp_out.push_back({d, exp_calls[i].size, mlast[i], 1'b0});
            if (kind[i] == 2) begin
                if (dec) begin
                    if (op_tag[t].data != z) exp_tag_ok = 1'b0;
                end else begin
                    exp_out.push_back({z, 3'd4, t == 3, 1'b1});
                end
                t++;
            end
            s = mix(s, exp_calls[i].dec ? d : (exp_calls[i].din & mask_of(exp_calls[i].size)), exp_calls[i].size);
        end
    endtask

    task automatic run_op(input bit dec, input bit stall, input int poke_at, output int lat);
        hw_t hq[$];
        int  k;
        bit  seen_done;
        for (int i = 0; i < 4; i++) hq.push_back(op_key[i]);
        for (int i = 0; i < 4; i++) hq.push_back(op_nonce[i]);
        foreach (op_ad[i]) hq.push_back(op_ad[i]);
        foreach (op_msg[i]) hq.push_back(op_msg[i]);
        if (dec) for (int i = 0; i < 4; i++) hq.push_back(op_tag[i]);
        call_log.delete(); got_out.delete(); init_cnt = 0;
        @(negedge clk);
        mode_decrypt = dec; start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        seen_done = 0; lat = -1; k = 0;
        while (!seen_done && k < 3000) begin
            @(negedge clk); k++;
            start = (k == poke_at);
            if (k == 1) chk("busy_after_start", 64'(busy), 64'd1);
            if (hq.size() > 0) begin
                s_data = hq[0].data; s_size = hq[0].size; s_last = hq[0].last;
                s_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            m_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (s_valid && s_ready) void'(hq.pop_front());
            if (m_valid && m_ready) got_out.push_back({m_data, m_size, m_last, m_tag});
            if (done) begin seen_done = 1; lat = k - 1; end
        end
        s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
        chk("done_seen", 64'(seen_done), 64'd1);
        chk("host_words_left", 64'(hq.size()), 64'd0);
    endtask

    task automatic compare_op(input bit stall, input int lat);
        int n;
        chk("calls_n", 64'(call_log.size()), 64'(exp_calls.size()));
        n = (call_log.size() < exp_calls.size()) ? call_log.size() : exp_calls.size();
        for (int i = 0; i < n; i++) chk($sformatf("call[%0d]", i), 64'(call_log[i]), 64'(exp_calls[i]));
        chk("init_n", 64'(init_cnt), 64'd1);
        chk("out_n", 64'(got_out.size()), 64'(exp_out.size()));
        n = (got_out.size() < exp_out.size()) ? got_out.size() : exp_out.size();
        for (int i = 0; i < n; i++) chk($sformatf("out[%0d]", i), 64'(got_out[i]), 64'(exp_out[i]));
        chk("tag_ok", 64'(tag_ok), 64'(exp_tag_ok));
        if (!stall) chk("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        chk("idle_after_done", 64'({busy, done}), 64'd0);
        chk("tag_ok_held", 64'(tag_ok), 64'(exp_tag_ok));
    endtask

    task automatic set_zero_op();
        for (int i = 0; i < 4; i++) begin op_key[i] = {32'd0, 3'd4, 1'b0}; op_nonce[i] = {32'd0, 3'd4, 1'b0}; end
        op_ad.delete(); op_msg.delete();
        op_ad.push_back({32'd0, 3'd0, 1'b1});
        op_msg.push_back({32'd0, 3'd0, 1'b1});
    endtask

    task automatic rand_seg(input bit is_msg, output hw_t q[$]);
        int n;
        logic [2:0] sz;
        logic [31:0] d;
        q.delete();
        n = $urandom_range(0, 3);
        if (n == 0) q.push_back({$urandom, 3'd0, 1'b1});
        for (int i = 0; i < n; i++) begin
            sz = (i == n - 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(4, 7));
            d = $urandom;
            if (is_msg) d = d & mask_of(sat(sz));
            q.push_back({d, sz, i == n - 1});
        end
    endtask

    out_t t1_out[$], t2_out[$];
    hw_t  pt_save[$], ct_words[$];
    hw_t  tag_save[4];
    int   lat;

    task automatic take_ct_and_tag();
        int t;
        ct_words.delete(); t = 0;
        foreach (got_out[i]) begin
            if (!got_out[i].tag) ct_words.push_back({got_out[i].data, got_out[i].size, got_out[i].last});
            else if (t < 4) begin tag_save[t] = {got_out[i].data, 3'd4, 1'b0}; t++; end
        end
    endtask

    task automatic check_roundtrip();
        chk("pt_n", 64'(got_out.size()), 64'(pt_save.size()));
        foreach (got_out[i])
            if (i < pt_save.size())
                chk($sformatf("pt[%0d]", i), 64'(got_out[i].data), 64'(pt_save[i].data & mask_of(sat(pt_save[i].size))));
    endtask

    initial begin
        hw_t q[$];
        int k;
        arstn = 1'b0;
        #12;
        chk("rst_status", 64'({busy, done, tag_ok}), 64'd0);
        chk("rst_core", 64'({core_enable, core_init, core_encrypt, core_decrypt, core_din_valid, core_dout_ready}), 64'd0);
        chk("rst_streams", 64'({s_ready, m_valid}), 64'd0);
        @(negedge clk) arstn = 1'b1;

        // all-zero key/nonce, empty AD and message
        set_zero_op();
        build_expect(0);
        run_op(0, 0, 0, lat);
        chk("t1_latency", 64'(lat), 64'd33);
        compare_op(0, lat);
        t1_out = got_out;

        // 4-byte AD, 7-byte message; one key word oversized and flagged last; start poked while busy
        for (int i = 0; i < 4; i++) begin op_key[i] = {$urandom, 3'd4, 1'b0}; op_nonce[i] = {$urandom, 3'd4, 1'b0}; end
        op_key[1] = {op_key[1].data, 3'd6, 1'b1};
        op_ad.delete(); op_msg.delete();
        op_ad.push_back({$urandom, 3'd4, 1'b1});
        op_msg.push_back({$urandom, 3'd4, 1'b0});
        op_msg.push_back({$urandom & 32'h00ff_ffff, 3'd3, 1'b1});
        pt_save = op_msg;
        build_expect(0);
        run_op(0, 0, 5, lat);
        compare_op(0, lat);
        if (got_out.size() >= 2) chk("ct_sizes", 64'({got_out[0].size, got_out[1].size}), 64'({3'd4, 3'd3}));
        t2_out = got_out;
        take_ct_and_tag();

        // decrypt with correct tag
        op_msg = ct_words;
        op_tag = tag_save;
        build_expect(1);
        run_op(1, 0, 0, lat);
        compare_op(0, lat);
        chk("t3_tag_ok", 64'(tag_ok), 64'd1);
        check_roundtrip();

        // decrypt with one tag bit flipped
        op_tag[2].data[5] = ~op_tag[2].data[5];
        build_expect(1);
        run_op(1, 0, 0, lat);
        compare_op(0, lat);
        chk("t4_tag_ok", 64'(tag_ok), 64'd0);

        // re-encrypt with random back-pressure; must match the unstalled run
        op_msg = pt_save;
        build_expect(0);
        run_op(0, 1, 0, lat);
        compare_op(1, lat);
        chk("stall_out_n", 64'(got_out.size()), 64'(t2_out.size()));
        foreach (got_out[i]) if (i < t2_out.size()) chk("stall_vs_unstalled", 64'(got_out[i]), 64'(t2_out[i]));

        // async reset mid-BLANK1, then rerun the zero test
        @(negedge clk);
        call_log.delete();
        mode_decrypt = 1'b0; start = 1'b1; m_ready = 1'b1;
        s_valid = 1'b1; s_data = 32'h1234_5678; s_size = 3'd4; s_last = 1'b0;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (call_log.size() < 12 && k < 200) begin @(negedge clk); k++; end
        chk("reached_blank1", 64'(call_log.size()), 64'd12);
        chk("busy_before_rst", 64'({busy, tag_ok}), 64'b11);
        #2 arstn = 1'b0;
        #1;
        chk("rst_mid_status", 64'({busy, done, tag_ok}), 64'd0);
        chk("rst_mid_core", 64'({core_enable, core_din_valid, s_ready, m_valid}), 64'd0);
        @(negedge clk) arstn = 1'b1; s_valid = 1'b0;
        set_zero_op();
        build_expect(0);
        run_op(0, 0, 0, lat);
        compare_op(0, lat);
        chk("rerun_n", 64'(got_out.size()), 64'(t1_out.size()));
        foreach (got_out[i]) if (i < t1_out.size()) chk("rerun_vs_first", 64'(got_out[i]), 64'(t1_out[i]));

        // randomized encrypt/decrypt round trips
        for (int it = 0; it < 6; it++) begin
            bit st;
            st = (it % 2 == 1);
            for (int i = 0; i < 4; i++) begin
                op_key[i] = {$urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
                op_nonce[i] = {$urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            end
            rand_seg(0, q); op_ad = q;
            rand_seg(1, q); op_msg = q;
            pt_save = op_msg;
            build_expect(0);
            run_op(0, st, 0, lat);
            compare_op(st, lat);
            take_ct_and_tag();
            op_msg = ct_words;
            op_tag = tag_save;
            build_expect(1);
            run_op(1, st, 0, lat);
            compare_op(st, lat);
            chk("rand_tag_ok", 64'(tag_ok), 64'd1);
            check_roundtrip();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
